// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the tone sequencer and its helpers.
package audio_pkg;

    localparam int unsigned PHASE_W     = 16;
    localparam int unsigned INDEX_SHIFT = 6;
    localparam int unsigned ROM_INDEX_W = 11;
    localparam int unsigned FREQ_ID_W   = 5;

    // freq_id whose ROM frequency is 0; plays silence for its duration
    localparam logic [FREQ_ID_W-1:0] FREQ_ID_REST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } tone_state_t;

endpackage

// File: rtl/tone_phase_acc.sv
// 16-bit phase accumulator: wraps naturally, exposes half-period sign and ROM index.
module tone_phase_acc
    import audio_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [PHASE_W-1:0]     freq,
    output logic                   sign,
    output logic [ROM_INDEX_W-1:0] index
);

    logic [PHASE_W-1:0] phase;

    // Phase register; clear wins over advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (advance) begin
            phase <= phase + freq;
        end
    end

    assign sign  = phase[PHASE_W-1];
    assign index = ROM_INDEX_W'(phase >> INDEX_SHIFT);

endmodule

// File: rtl/tone_player.sv
// Note sequencer that shares the sine/frequency ROM with the display renderer.
module tone_player
    import audio_pkg::*;
#(
    parameter int unsigned BITS  = 6,
    parameter int unsigned DUR_W = 16
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_tick,
    input  logic                   note_valid,
    output logic                   note_ready,
    input  logic [4:0]             note_id,
    input  logic [DUR_W-1:0]       note_dur,
    input  logic                   abort,
    output logic [10:0]            rom_index,
    output logic [4:0]             rom_freq_id,
    input  logic [BITS-1:0]        rom_level,
    input  logic [15:0]            rom_freq,
    input  logic                   disp_req,
    input  logic [10:0]            disp_index,
    output logic                   disp_gnt,
    output logic [BITS-1:0]        disp_level,
    output logic                   disp_level_valid,
    output logic signed [BITS:0]   audio_sample,
    output logic                   audio_valid,
    output logic                   busy
);

    tone_state_t            state;
    logic [FREQ_ID_W-1:0]   id_reg;
    logic [DUR_W-1:0]       dur_cnt;
    logic [PHASE_W-1:0]     freq_reg;

    logic                   audio_slot;
    logic                   accept;
    logic                   phase_clear;
    logic                   phase_adv;
    logic                   phase_sign;
    logic [ROM_INDEX_W-1:0] phase_index;
    logic [BITS:0]          level_ext;
    logic [BITS:0]          sample_next;

    assign note_ready  = (state == IDLE) & ~abort;
    assign accept      = note_valid & note_ready;
    assign audio_slot  = (state == PLAY) & sample_tick;
    assign disp_gnt    = disp_req & ~audio_slot;
    assign rom_freq_id = (state == IDLE) ? '0 : id_reg;
    assign busy        = (state != IDLE);

    assign phase_clear = abort | accept;
    assign phase_adv   = audio_slot & (id_reg != FREQ_ID_REST);

    tone_phase_acc u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (phase_clear),
        .advance (phase_adv),
        .freq    (freq_reg),
        .sign    (phase_sign),
        .index   (phase_index)
    );

    // ROM index arbitration: audio owns the port on its tick, display otherwise
    always_comb begin
        rom_index = '0;
        if (audio_slot) begin
            rom_index = phase_index;
        end else if (disp_gnt) begin
            rom_index = disp_index;
        end
    end

    // Second half of the period plays the negated level
    always_comb begin
        level_ext   = {1'b0, rom_level};
        sample_next = phase_sign ? ((BITS+1)'(0) - level_ext) : level_ext;
    end

    // Note sequencer; abort overrides everything including a pending note
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            id_reg   <= '0;
            dur_cnt  <= '0;
            freq_reg <= '0;
        end else if (abort) begin
            state   <= IDLE;
            dur_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (note_valid) begin
                        id_reg  <= note_id;
                        dur_cnt <= (note_dur == '0) ? DUR_W'(1) : note_dur;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    freq_reg <= rom_freq;
                    state    <= PLAY;
                end
                PLAY: begin
                    if (sample_tick) begin
                        dur_cnt <= dur_cnt - DUR_W'(1);
                        if (dur_cnt == DUR_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered audio and display results, one cycle after their ROM slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_sample     <= '0;
            audio_valid      <= 1'b0;
            disp_level       <= '0;
            disp_level_valid <= 1'b0;
        end else begin
            audio_valid      <= sample_tick;
            disp_level_valid <= disp_gnt;
            if (sample_tick) begin
                audio_sample <= audio_slot ? sample_next : '0;
            end
            if (disp_gnt) begin
                disp_level <= rom_level;
            end
        end
    end

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player with a behavioural ROM (level = index[9:4]).
module tb_tone_player;

    logic               clk;
    logic               rst_n;
    logic               sample_tick;
    logic               note_valid;
    logic               note_ready;
    logic [4:0]         note_id;
    logic [15:0]        note_dur;
    logic               abort;
    logic [10:0]        rom_index;
    logic [4:0]         rom_freq_id;
    logic [5:0]         rom_level;
    logic [15:0]        rom_freq;
    logic               disp_req;
    logic [10:0]        disp_index;
    logic               disp_gnt;
    logic [5:0]         disp_level;
    logic               disp_level_valid;
    logic signed [6:0]  audio_sample;
    logic               audio_valid;
    logic               busy;

    int pass_cnt;
    int total_cnt;

    tone_player #(.BITS(6), .DUR_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_tick      (sample_tick),
        .note_valid       (note_valid),
        .note_ready       (note_ready),
        .note_id          (note_id),
        .note_dur         (note_dur),
        .abort            (abort),
        .rom_index        (rom_index),
        .rom_freq_id      (rom_freq_id),
        .rom_level        (rom_level),
        .rom_freq         (rom_freq),
        .disp_req         (disp_req),
        .disp_index       (disp_index),
        .disp_gnt         (disp_gnt),
        .disp_level       (disp_level),
        .disp_level_valid (disp_level_valid),
        .audio_sample     (audio_sample),
        .audio_valid      (audio_valid),
        .busy             (busy)
    );

    // Behavioural ROM
    assign rom_level = rom_index[9:4];
    always_comb begin
        case (rom_freq_id)
            5'd24:   rom_freq = 16'd7268;
            5'd16:   rom_freq = 16'd16384;
            5'd31:   rom_freq = 16'd0;
            default: rom_freq = 16'(rom_freq_id) * 16'd100;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic tick;
        logic req;
        int   didx;
        int   e_idx;
        int   e_gnt;
        int   e_av;
        int   e_smp;
        int   e_dlv;
        int   e_dl;
        int   e_busy;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic send_note(input int id, input int dur);
        @(negedge clk);
        note_valid = 1'b1;
        note_id    = 5'(id);
        note_dur   = 16'(dur);
        #1;
        chk("ready_idle", id, int'(note_ready), 1);
        @(posedge clk);
        #1;
        chk("busy_load", id, int'(busy), 1);
        @(negedge clk);
        note_valid = 1'b0;
        #1;
        chk("freq_id_load", id, int'(rom_freq_id), id);
        chk("ready_load", id, int'(note_ready), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            sample_tick = vecs[i].tick;
            disp_req    = vecs[i].req;
            disp_index  = 11'(vecs[i].didx);
            #1;
            chk("rom_index", i, int'(rom_index), vecs[i].e_idx);
            chk("disp_gnt", i, int'(disp_gnt), vecs[i].e_gnt);
            @(posedge clk);
            #1;
            chk("audio_valid", i, int'(audio_valid), vecs[i].e_av);
            chk("audio_sample", i, int'(audio_sample), vecs[i].e_smp);
            chk("disp_lvl_valid", i, int'(disp_level_valid), vecs[i].e_dlv);
            chk("disp_level", i, int'(disp_level), vecs[i].e_dl);
            chk("busy", i, int'(busy), vecs[i].e_busy);
        end
        @(negedge clk);
        sample_tick = 1'b0;
        disp_req    = 1'b0;
    endtask

    initial begin
        // note 24 (freq 7268), dur 3, display requests interleaved
        vecs[0]  = '{1'b0, 1'b1, 100, 100, 1, 0,   0, 1,  6, 1};
        vecs[1]  = '{1'b1, 1'b1, 200,   0, 0, 1,   0, 0,  6, 1};
        vecs[2]  = '{1'b0, 1'b1, 300, 300, 1, 0,   0, 1, 18, 1};
        vecs[3]  = '{1'b1, 1'b0,   0, 113, 0, 1,   7, 0, 18, 1};
        vecs[4]  = '{1'b0, 1'b0,   0,   0, 0, 0,   7, 0, 18, 1};
        vecs[5]  = '{1'b1, 1'b1,  50, 227, 0, 1,  14, 0, 18, 0};
        vecs[6]  = '{1'b0, 1'b1, 640, 640, 1, 0,  14, 1, 40, 0};
        vecs[7]  = '{1'b1, 1'b1,  16,  16, 1, 1,   0, 1,  1, 0};
        // note 16 (freq 16384), dur 5: quarter-period steps through a full wrap
        vecs[8]  = '{1'b1, 1'b0,   0,   0, 0, 1,   0, 0,  1, 1};
        vecs[9]  = '{1'b0, 1'b0,   0,   0, 0, 0,   0, 0,  1, 1};
        vecs[10] = '{1'b1, 1'b0,   0, 256, 0, 1,  16, 0,  1, 1};
        vecs[11] = '{1'b0, 1'b0,   0,   0, 0, 0,  16, 0,  1, 1};
        vecs[12] = '{1'b1, 1'b0,   0, 512, 0, 1, -32, 0,  1, 1};
        vecs[13] = '{1'b0, 1'b0,   0,   0, 0, 0, -32, 0,  1, 1};
        vecs[14] = '{1'b1, 1'b0,   0, 768, 0, 1, -48, 0,  1, 1};
        vecs[15] = '{1'b0, 1'b0,   0,   0, 0, 0, -48, 0,  1, 1};
        vecs[16] = '{1'b1, 1'b0,   0,   0, 0, 1,   0, 0,  1, 0};
        // rest note, dur 0 -> exactly one silent tick
        vecs[17] = '{1'b1, 1'b0,   0,   0, 0, 1,   0, 0,  1, 0};

        pass_cnt    = 0;
        total_cnt   = 0;
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        note_valid  = 1'b0;
        note_id     = '0;
        note_dur    = '0;
        abort       = 1'b0;
        disp_req    = 1'b0;
        disp_index  = '0;

        #1;
        chk("rst_ready", 0, int'(note_ready), 1);
        chk("rst_busy", 0, int'(busy), 0);
        chk("rst_rom_index", 0, int'(rom_index), 0);
        chk("rst_freq_id", 0, int'(rom_freq_id), 0);
        chk("rst_sample", 0, int'(audio_sample), 0);
        chk("rst_valid", 0, int'(audio_valid), 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_note(24, 3);
        run_vecs(0, 7);
        send_note(16, 5);
        run_vecs(8, 16);
        send_note(31, 0);
        run_vecs(17, 17);

        // abort together with a new note while playing
        send_note(24, 10);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        abort       = 1'b1;
        note_valid  = 1'b1;
        note_id     = 5'd5;
        note_dur    = 16'd4;
        #1;
        chk("abort_ready", 0, int'(note_ready), 0);
        chk("abort_busy_pre", 0, int'(busy), 1);
        @(posedge clk);
        #1;
        chk("abort_busy", 0, int'(busy), 0);
        @(negedge clk);
        abort      = 1'b0;
        note_valid = 1'b0;
        #1;
        chk("abort_ready_after", 0, int'(note_ready), 1);
        chk("abort_freq_id", 0, int'(rom_freq_id), 0);
        @(negedge clk);
        sample_tick = 1'b1;
        #1;
        chk("abort_rom_index", 0, int'(rom_index), 0);
        @(posedge clk);
        #1;
        chk("abort_valid", 0, int'(audio_valid), 1);
        chk("abort_sample", 0, int'(audio_sample), 0);
        chk("abort_not_taken", 0, int'(busy), 0);
        @(negedge clk);
        sample_tick = 1'b0;

        // asynchronous reset in the middle of a note
        send_note(16, 5);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            sample_tick = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("pre_reset_sample", 0, int'(audio_sample), 16);
        chk("pre_reset_busy", 0, int'(busy), 1);
        sample_tick = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sample", 0, int'(audio_sample), 0);
        chk("async_valid", 0, int'(audio_valid), 0);
        chk("async_busy", 0, int'(busy), 0);
        chk("async_ready", 0, int'(note_ready), 1);
        chk("async_rom_index", 0, int'(rom_index), 0);
        chk("async_freq_id", 0, int'(rom_freq_id), 0);
        chk("async_disp_level", 0, int'(disp_level), 0);
        chk("async_disp_valid", 0, int'(disp_level_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
